// File: rtl/apb_requester_queue.sv
// apb_requester_queue
// Queued APB requester. Commands are pushed into a small command FIFO,
// executed one at a time as APB SETUP/ACCESS transfers, and their results
// are returned in order through a response FIFO.
//
// Handshake semantics (both ports): a transfer happens on a CLK edge where
// VALID=1 and READY=1. The producer holds its payload stable while VALID=1
// and READY=0. CMD_READY depends only on registered FIFO state, so a pop in
// the same cycle does not open a slot. RSP_VALID is "response FIFO
// non-empty", and RSP_RDATA/RSP_ERR are held until the pop.

module apb_requester_queue #(
   parameter int C_ADDR_BITS  = 10,
   parameter int C_DATA_BITS  = 32,
   parameter int C_FIFO_DEPTH = 4,
   parameter int C_TIME_OUT   = 3000
) (
   input  logic                       CLK,
   input  logic                       RST,
   // command push port
   input  logic                       CMD_VALID,
   output logic                       CMD_READY,
   input  logic                       CMD_WRITE,
   input  logic [C_ADDR_BITS-1:0]     CMD_ADDR,
   input  logic [C_DATA_BITS-1:0]     CMD_WDATA,
   input  logic [C_DATA_BITS/8-1:0]   CMD_STRB,
   // response pop port
   output logic                       RSP_VALID,
   input  logic                       RSP_READY,
   output logic [C_DATA_BITS-1:0]     RSP_RDATA,
   output logic [1:0]                 RSP_ERR,
   // APB requester
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [C_ADDR_BITS-1:0]     PADDR,
   output logic [C_DATA_BITS-1:0]     PWDATA,
   output logic [C_DATA_BITS/8-1:0]   PSTRB,
   input  logic [C_DATA_BITS-1:0]     PRDATA,
   input  logic                       PREADY,
   input  logic                       PSLVERR,
   // status
   output logic                       BUSY
);

   localparam int SW = C_DATA_BITS / 8;
   localparam int AW = $clog2(C_FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = 1 + C_ADDR_BITS + C_DATA_BITS + SW;
   localparam int RW = 2 + C_DATA_BITS;
   localparam int TW = (C_TIME_OUT < 2) ? 1 : $clog2(C_TIME_OUT + 1);

   // Last counter value before the transfer is abandoned; unused when the
   // timeout is disabled.
   localparam logic [TW-1:0] TO_LAST = TW'((C_TIME_OUT == 0) ? 0 : C_TIME_OUT - 1);

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_SLVERR  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // FSM state, visible by name for checkers and waveform viewers
   state_t                fsm_state;
   state_t                fsm_state_nxt;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [CW-1:0]          cmd_mem [C_FIFO_DEPTH];
   logic [PW-1:0]          cmd_wr_ptr;
   logic [PW-1:0]          cmd_rd_ptr;
   logic                   cmd_empty;
   logic                   cmd_full;
   logic                   cmd_push;
   logic                   cmd_pop;
   logic [CW-1:0]          cmd_head;
   logic                   head_write;
   logic [C_ADDR_BITS-1:0] head_addr;
   logic [C_DATA_BITS-1:0] head_wdata;
   logic [SW-1:0]          head_strb;

   assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
   assign cmd_full  = (cmd_wr_ptr[AW] != cmd_rd_ptr[AW]) &&
                      (cmd_wr_ptr[AW-1:0] == cmd_rd_ptr[AW-1:0]);

   // Held low through reset so nothing is accepted while flushing.
   assign CMD_READY = ~cmd_full & ~RST;
   assign cmd_push  = CMD_VALID & CMD_READY;

   assign cmd_head   = cmd_mem[cmd_rd_ptr[AW-1:0]];
   assign head_write = cmd_head[CW-1];
   assign head_addr  = cmd_head[CW-2 -: C_ADDR_BITS];
   assign head_wdata = cmd_head[SW +: C_DATA_BITS];
   assign head_strb  = cmd_head[SW-1:0];

   // Command pointers: wrap modulo 2*depth, reset flushes the queue
   always_ff @(posedge CLK) begin
      if (RST) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
      end
   end

   // Command storage: payload only, needs no reset
   always_ff @(posedge CLK) begin
      if (cmd_push) cmd_mem[cmd_wr_ptr[AW-1:0]] <= {CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_STRB};
   end

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   logic [RW-1:0]          rsp_mem [C_FIFO_DEPTH];
   logic [PW-1:0]          rsp_wr_ptr;
   logic [PW-1:0]          rsp_rd_ptr;
   logic [PW-1:0]          rsp_count;
   logic [PW:0]            rsp_count_after;
   logic                   rsp_empty;
   logic                   rsp_push;
   logic                   rsp_pop;
   logic [RW-1:0]          rsp_push_data;
   logic [RW-1:0]          rsp_head;

   assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
   assign rsp_count = rsp_wr_ptr - rsp_rd_ptr;
   assign rsp_head  = rsp_mem[rsp_rd_ptr[AW-1:0]];

   assign RSP_VALID = ~rsp_empty;
   assign rsp_pop   = RSP_VALID & RSP_READY;

   // Payload is forced to zero when nothing is queued, so reset and idle
   // both present a clean all-zero response bus.
   assign RSP_RDATA = RSP_VALID ? rsp_head[C_DATA_BITS-1:0] : '0;
   assign RSP_ERR   = RSP_VALID ? rsp_head[RW-1 -: 2] : ERR_OK;

   // Occupancy once the response completing this cycle has been pushed.
   assign rsp_count_after = {1'b0, rsp_count} + (PW+1)'(1) - (PW+1)'(rsp_pop);

   // Response pointers: wrap modulo 2*depth, reset drops pending responses
   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_wr_ptr <= '0;
         rsp_rd_ptr <= '0;
      end else begin
         if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PW'(1);
         if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PW'(1);
      end
   end

   // Response storage: payload only, needs no reset
   always_ff @(posedge CLK) begin
      if (rsp_push && !RST) rsp_mem[rsp_wr_ptr[AW-1:0]] <= rsp_push_data;
   end

   // ------------------------------------------------------------------
   // Transfer control
   // ------------------------------------------------------------------
   logic [TW-1:0]          tcnt;
   logic [TW-1:0]          tcnt_nxt;
   logic                   timeout_hit;
   logic                   xfer_done;
   logic                   can_start;
   logic                   can_chain;

   logic                   psel_nxt;
   logic                   penable_nxt;
   logic                   pwrite_nxt;
   logic [C_ADDR_BITS-1:0] paddr_nxt;
   logic [C_DATA_BITS-1:0] pwdata_nxt;
   logic [SW-1:0]          pstrb_nxt;

   // The timeout cycle wins over PREADY arriving in that same cycle.
   assign timeout_hit = (C_TIME_OUT != 0) && (fsm_state == ST_ACCESS) && (tcnt == TO_LAST);
   assign xfer_done   = (fsm_state == ST_ACCESS) && (timeout_hit || PREADY);

   // A new transfer only starts if its response is guaranteed a slot.
   assign can_start = ~cmd_empty && (rsp_count < PW'(C_FIFO_DEPTH));
   assign can_chain = ~cmd_empty && (rsp_count_after < (PW+1)'(C_FIFO_DEPTH));

   assign BUSY = (fsm_state != ST_IDLE) || ~cmd_empty;

   // State and registered APB outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         fsm_state <= ST_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         tcnt      <= '0;
      end else begin
         fsm_state <= fsm_state_nxt;
         PSEL      <= psel_nxt;
         PENABLE   <= penable_nxt;
         PWRITE    <= pwrite_nxt;
         PADDR     <= paddr_nxt;
         PWDATA    <= pwdata_nxt;
         PSTRB     <= pstrb_nxt;
         tcnt      <= tcnt_nxt;
      end
   end

   // Next-state decision
   always_comb begin
      fsm_state_nxt = fsm_state;
      case (fsm_state)
         ST_IDLE:   if (can_start) fsm_state_nxt = ST_SETUP;
         ST_SETUP:  fsm_state_nxt = ST_ACCESS;
         ST_ACCESS: if (xfer_done) fsm_state_nxt = can_chain ? ST_SETUP : ST_IDLE;
         default:   fsm_state_nxt = ST_IDLE;
      endcase
   end

   // Next APB register values, FIFO pop/push and timeout counter
   always_comb begin
      psel_nxt      = (fsm_state_nxt != ST_IDLE);
      penable_nxt   = (fsm_state_nxt == ST_ACCESS);
      pwrite_nxt    = PWRITE;
      paddr_nxt     = PADDR;
      pwdata_nxt    = PWDATA;
      pstrb_nxt     = PSTRB;
      cmd_pop       = 1'b0;
      rsp_push      = 1'b0;
      rsp_push_data = '0;
      tcnt_nxt      = tcnt;

      // Entering SETUP always consumes the head command; reads carry no
      // data or strobes on the bus.
      if (fsm_state_nxt == ST_SETUP) begin
         cmd_pop    = 1'b1;
         pwrite_nxt = head_write;
         paddr_nxt  = head_addr;
         pwdata_nxt = head_write ? head_wdata : '0;
         pstrb_nxt  = head_write ? head_strb  : '0;
      end

      if (fsm_state == ST_SETUP) begin
         tcnt_nxt = '0;
      end else if (fsm_state == ST_ACCESS && !PREADY && C_TIME_OUT != 0) begin
         tcnt_nxt = tcnt + TW'(1);
      end

      if (xfer_done) begin
         rsp_push = 1'b1;
         if (timeout_hit) begin
            rsp_push_data = {ERR_TIMEOUT, {C_DATA_BITS{1'b0}}};
         end else begin
            rsp_push_data = {(PSLVERR ? ERR_SLVERR : ERR_OK),
                             (PWRITE ? {C_DATA_BITS{1'b0}} : PRDATA)};
         end
      end
   end

endmodule

// File: tb/tb_apb_requester_queue.sv
// tb_apb_requester_queue
// Directed bench for apb_requester_queue: reset, single write, read with
// wait states and slave error, timeout, FIFO backpressure, back-to-back
// transfers and reset in the middle of a transfer.

module tb_apb_requester_queue;

   localparam int A = 10;
   localparam int D = 32;
   localparam int S = D / 8;
   localparam int W = 2 + D;

   logic          CLK = 1'b0;
   logic          RST;
   logic          CMD_VALID;
   logic          CMD_READY;
   logic          CMD_WRITE;
   logic [A-1:0]  CMD_ADDR;
   logic [D-1:0]  CMD_WDATA;
   logic [S-1:0]  CMD_STRB;
   logic          RSP_VALID;
   logic          RSP_READY;
   logic [D-1:0]  RSP_RDATA;
   logic [1:0]    RSP_ERR;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [A-1:0]  PADDR;
   logic [D-1:0]  PWDATA;
   logic [S-1:0]  PSTRB;
   logic [D-1:0]  PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic          BUSY;

   // Slave read data: either a fixed value or a pattern derived from PADDR
   logic          use_model;
   logic [D-1:0]  prdata_drv;
   assign PRDATA = use_model ? (32'hCAFE_0000 | {22'h0, PADDR}) : prdata_drv;

   int checks = 0;
   int passes = 0;
   logic [W-1:0] exp_q[$];

   apb_requester_queue #(
      .C_ADDR_BITS(A), .C_DATA_BITS(D), .C_FIFO_DEPTH(4), .C_TIME_OUT(5)
   ) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .BUSY(BUSY)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // ---------------- drivers ----------------
   task automatic set_cmd(input logic v, input logic wr, input logic [A-1:0] addr,
                          input logic [D-1:0] wdata, input logic [S-1:0] strb);
      CMD_VALID = v;
      CMD_WRITE = wr;
      CMD_ADDR  = addr;
      CMD_WDATA = wdata;
      CMD_STRB  = strb;
   endtask

   // Offer one command and wait (bounded) until it is accepted.
   task automatic push_cmd(input logic wr, input logic [A-1:0] addr,
                           input logic [D-1:0] wdata, input logic [S-1:0] strb);
      int waited = 0;
      set_cmd(1'b1, wr, addr, wdata, strb);
      while (CMD_READY !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      if (CMD_READY !== 1'b1) begin
         checks++;
         $display("FAIL cmd_accept: CMD_READY stayed %b for addr %h, want 1", CMD_READY, addr);
      end
      tick();
      CMD_VALID = 1'b0;
   endtask

   // Scoreboard: pop every outstanding response and compare in order.
   task automatic drain_rsp();
      logic [W-1:0] exp_v;
      int waited;
      while (exp_q.size() > 0) begin
         waited = 0;
         while (RSP_VALID !== 1'b1 && waited < 50) begin
            tick();
            waited++;
         end
         checks++;
         if (RSP_VALID !== 1'b1) begin
            $display("FAIL rsp_wait: RSP_VALID=%b with %0d responses outstanding, want 1", RSP_VALID, exp_q.size());
            exp_q.delete();
         end else begin
            exp_v = exp_q.pop_front();
            if ({RSP_ERR, RSP_RDATA} !== exp_v)
               $display("FAIL rsp_data: got err=%0d data=%h, want err=%0d data=%h",
                        RSP_ERR, RSP_RDATA, exp_v[W-1 -: 2], exp_v[D-1:0]);
            else passes++;
            RSP_READY = 1'b1;
            tick();
            RSP_READY = 1'b0;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) $display("FAIL rst_apb: PSEL=%b PENABLE=%b, want 0 0", PSEL, PENABLE); else passes++;
      checks++; if ({PWRITE, PADDR, PWDATA, PSTRB} !== '0) $display("FAIL rst_bus: PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%h, want all 0", PWRITE, PADDR, PWDATA, PSTRB); else passes++;
      checks++; if (RSP_VALID !== 1'b0 || RSP_ERR !== 2'd0 || RSP_RDATA !== '0) $display("FAIL rst_rsp: valid=%b err=%0d data=%h, want 0 0 0", RSP_VALID, RSP_ERR, RSP_RDATA); else passes++;
      checks++; if (CMD_READY !== 1'b0 || BUSY !== 1'b0) $display("FAIL rst_ready_busy: CMD_READY=%b BUSY=%b, want 0 0", CMD_READY, BUSY); else passes++;
      RST = 1'b0;
      #1;
      checks++; if (CMD_READY !== 1'b1) $display("FAIL rst_release_ready: CMD_READY=%b, want 1", CMD_READY); else passes++;
      tick();
   endtask

   task automatic test_single_write();
      PREADY = 1'b1; PSLVERR = 1'b0; RSP_READY = 1'b0;
      push_cmd(1'b1, 10'h004, 32'hA5A5_A5A5, 4'hF);
      checks++; if (PSEL !== 1'b0 || BUSY !== 1'b1) $display("FAIL wr_t0: PSEL=%b BUSY=%b, want 0 1", PSEL, BUSY); else passes++;
      tick();
      checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) $display("FAIL wr_setup: PSEL=%b PENABLE=%b, want 1 0", PSEL, PENABLE); else passes++;
      checks++; if (PWRITE !== 1'b1 || PADDR !== 10'h004 || PWDATA !== 32'hA5A5_A5A5 || PSTRB !== 4'hF)
         $display("FAIL wr_bus: PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%h, want 1 004 a5a5a5a5 f", PWRITE, PADDR, PWDATA, PSTRB); else passes++;
      tick();
      checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || RSP_VALID !== 1'b0) $display("FAIL wr_access: PSEL=%b PENABLE=%b RSP_VALID=%b, want 1 1 0", PSEL, PENABLE, RSP_VALID); else passes++;
      tick();
      checks++; if (RSP_VALID !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL wr_done: RSP_VALID=%b PSEL=%b PENABLE=%b BUSY=%b, want 1 0 0 0", RSP_VALID, PSEL, PENABLE, BUSY); else passes++;
      exp_q.push_back({2'd0, 32'h0});
      drain_rsp();
   endtask

   task automatic test_read_wait_err();
      int en_cycles = 0;
      use_model = 1'b0; prdata_drv = 32'h1234_5678;
      PREADY = 1'b0; PSLVERR = 1'b1; RSP_READY = 1'b0;
      push_cmd(1'b0, 10'h010, 32'hFFFF_FFFF, 4'hF);
      tick();
      checks++; if (PSEL !== 1'b1 || PWRITE !== 1'b0 || PADDR !== 10'h010 || PSTRB !== 4'h0 || PWDATA !== 32'h0)
         $display("FAIL rd_setup: PSEL=%b PWRITE=%b PADDR=%h PSTRB=%h PWDATA=%h, want 1 0 010 0 0", PSEL, PWRITE, PADDR, PSTRB, PWDATA); else passes++;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) PREADY = 1'b1;
         if (PENABLE === 1'b1 && PADDR === 10'h010) en_cycles++;
         tick();
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
      checks++; if (en_cycles != 4) $display("FAIL rd_enable_len: PENABLE high %0d cycles, want 4", en_cycles); else passes++;
      checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) $display("FAIL rd_end: PSEL=%b PENABLE=%b, want 0 0", PSEL, PENABLE); else passes++;
      checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h1234_5678 || RSP_ERR !== 2'd1)
         $display("FAIL rd_rsp: valid=%b data=%h err=%0d, want 1 12345678 1", RSP_VALID, RSP_RDATA, RSP_ERR); else passes++;
      tick();
      checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h1234_5678 || RSP_ERR !== 2'd1)
         $display("FAIL rd_rsp_hold: valid=%b data=%h err=%0d, want 1 12345678 1", RSP_VALID, RSP_RDATA, RSP_ERR); else passes++;
      exp_q.push_back({2'd1, 32'h1234_5678});
      drain_rsp();
   endtask

   task automatic test_timeout();
      int en_cycles = 0;
      use_model = 1'b1;
      PREADY = 1'b0; PSLVERR = 1'b0; RSP_READY = 1'b0;
      push_cmd(1'b1, 10'h020, 32'h0000_0011, 4'h3);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         if (PENABLE === 1'b1) en_cycles++;
         tick();
      end
      checks++; if (en_cycles != 5) $display("FAIL to_enable_len: PENABLE high %0d cycles, want 5", en_cycles); else passes++;
      checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) $display("FAIL to_end: PSEL=%b PENABLE=%b, want 0 0", PSEL, PENABLE); else passes++;
      checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 2'd2 || RSP_RDATA !== 32'h0)
         $display("FAIL to_rsp: valid=%b err=%0d data=%h, want 1 2 0", RSP_VALID, RSP_ERR, RSP_RDATA); else passes++;
      exp_q.push_back({2'd2, 32'h0});
      drain_rsp();
      // The following command still runs normally.
      PREADY = 1'b1;
      push_cmd(1'b0, 10'h024, 32'h0, 4'h0);
      exp_q.push_back({2'd0, 32'hCAFE_0024});
      drain_rsp();
      // PREADY arriving in the fifth ACCESS cycle is too late: still a timeout.
      PREADY = 1'b0;
      push_cmd(1'b0, 10'h028, 32'h0, 4'h0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) PREADY = 1'b1;
         tick();
      end
      PREADY = 1'b0;
      exp_q.push_back({2'd2, 32'h0});
      drain_rsp();
   endtask

   task automatic test_fifo_full();
      logic psel_seen = 1'b0;
      logic [A-1:0] addr;
      use_model = 1'b1;
      PREADY = 1'b1; PSLVERR = 1'b0; RSP_READY = 1'b0;
      for (int i = 0; i < 6; i++) begin
         addr = 10'h040 + A'(i * 4);
         push_cmd(1'b0, addr, 32'h0, 4'h0);
         exp_q.push_back({2'd0, 32'hCAFE_0000 | {22'h0, addr}});
      end
      for (int i = 0; i < 8; i++) tick();
      for (int i = 0; i < 8; i++) begin
         psel_seen |= PSEL;
         tick();
      end
      checks++; if (psel_seen !== 1'b0) $display("FAIL full_stall: PSEL went high with 4 responses queued, want 0"); else passes++;
      checks++; if (RSP_VALID !== 1'b1 || BUSY !== 1'b1) $display("FAIL full_state: RSP_VALID=%b BUSY=%b, want 1 1", RSP_VALID, BUSY); else passes++;
      for (int i = 6; i < 8; i++) begin
         addr = 10'h040 + A'(i * 4);
         push_cmd(1'b0, addr, 32'h0, 4'h0);
         exp_q.push_back({2'd0, 32'hCAFE_0000 | {22'h0, addr}});
      end
      checks++; if (CMD_READY !== 1'b0) $display("FAIL full_cmd_ready: CMD_READY=%b with command FIFO full, want 0", CMD_READY); else passes++;
      drain_rsp();
      checks++; if (BUSY !== 1'b0 || RSP_VALID !== 1'b0) $display("FAIL full_drained: BUSY=%b RSP_VALID=%b, want 0 0", BUSY, RSP_VALID); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] pattern_bad = 2'b00;
      logic en_exp;
      use_model = 1'b1;
      PREADY = 1'b1; PSLVERR = 1'b0; RSP_READY = 1'b0;
      set_cmd(1'b1, 1'b0, 10'h080, 32'h0, 4'h0);
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i < 2) set_cmd(1'b1, 1'b0, 10'h080 + A'((i + 1) * 4), 32'h0, 4'h0);
         else CMD_VALID = 1'b0;
         tick();
         en_exp = (i % 2 == 1);
         if (PSEL !== 1'b1) pattern_bad[0] = 1'b1;
         if (PENABLE !== en_exp) pattern_bad[1] = 1'b1;
      end
      checks++; if (pattern_bad[0]) $display("FAIL b2b_psel: PSEL dropped during back-to-back run, want continuously 1"); else passes++;
      checks++; if (pattern_bad[1]) $display("FAIL b2b_penable: PENABLE did not follow 0,1,0,1,0,1"); else passes++;
      tick();
      checks++; if (PSEL !== 1'b0) $display("FAIL b2b_end: PSEL=%b, want 0", PSEL); else passes++;
      exp_q.push_back({2'd0, 32'hCAFE_0080});
      exp_q.push_back({2'd0, 32'hCAFE_0084});
      exp_q.push_back({2'd0, 32'hCAFE_0088});
      drain_rsp();
   endtask

   task automatic test_reset_mid_transfer();
      logic rsp_seen = 1'b0;
      logic psel_seen = 1'b0;
      PREADY = 1'b0; PSLVERR = 1'b0; RSP_READY = 1'b0;
      push_cmd(1'b1, 10'h100, 32'h1, 4'hF);
      push_cmd(1'b1, 10'h104, 32'h2, 4'hF);
      push_cmd(1'b1, 10'h108, 32'h3, 4'hF);
      checks++; if (PENABLE !== 1'b1 || PADDR !== 10'h100) $display("FAIL rstmid_pre: PENABLE=%b PADDR=%h, want 1 100", PENABLE, PADDR); else passes++;
      RST = 1'b1;
      tick();
      checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || BUSY !== 1'b0 || RSP_VALID !== 1'b0)
         $display("FAIL rstmid_drop: PSEL=%b PENABLE=%b BUSY=%b RSP_VALID=%b, want 0 0 0 0", PSEL, PENABLE, BUSY, RSP_VALID); else passes++;
      RST = 1'b0;
      PREADY = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         rsp_seen  |= RSP_VALID;
         psel_seen |= PSEL;
      end
      checks++; if (rsp_seen !== 1'b0 || psel_seen !== 1'b0)
         $display("FAIL rstmid_after: RSP_VALID seen=%b PSEL seen=%b after reset, want 0 0", rsp_seen, psel_seen); else passes++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      RST = 1'b1;
      set_cmd(1'b0, 1'b0, '0, '0, '0);
      RSP_READY = 1'b0;
      PREADY = 1'b0;
      PSLVERR = 1'b0;
      use_model = 1'b1;
      prdata_drv = '0;
      @(negedge CLK);
      test_reset();
      test_single_write();
      test_read_wait_err();
      test_timeout();
      test_fifo_full();
      test_back_to_back();
      test_reset_mid_transfer();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
